// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: walks A,B,C through all 8 vectors and checks the
// NAND-only and NOR-only builds of F = A' + BC against the expected F.
//
// Ports:
//   clk, rst_n      clock (rising edge), async active-low reset
//   start           level-sampled run request (IDLE or DONE only)
//   y_nand, y_nor   responses of the two gate-level implementations
//   A, B, C         registered stimulus, {A,B,C} = vector index
//   busy, done      run in progress / results valid
//   pass            no mismatches in the last run (valid while done)
//   nand_ok_mask    bit i set when y_nand matched at vector i
//   nor_ok_mask     bit i set when y_nor matched at vector i
//   err_count       total mismatches, 0..16
//   first_fail      {valid, index} of first failing vector
//
// Build option: FIRST_FAIL_CAPTURE_EN enables first_fail capture;
// without it first_fail is tied to zero.
module truth_table_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_nand,
    input  logic       y_nor,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] nand_ok_mask,
    output logic [7:0] nor_ok_mask,
    output logic [4:0] err_count,
    output logic [3:0] first_fail
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // F = ~A | (B & C) over vectors 7..0
    localparam logic [7:0] EXP = 8'h8F;
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t      state_q;
    logic [2:0]  vec_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [7:0]  nand_mask_q;
    logic [7:0]  nor_mask_q;
    logic [4:0]  err_q;

    logic        exp_f;
    logic        nand_hit;
    logic        nor_hit;
    logic [4:0]  err_d;
    logic [7:0]  nand_mask_d;
    logic [7:0]  nor_mask_d;

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [3:0]  ff_q;
`endif

    always_comb begin
        exp_f       = EXP[vec_q];
        nand_hit    = (y_nand == exp_f);
        nor_hit     = (y_nor == exp_f);
        err_d       = err_q + {4'b0, ~nand_hit}
                            + {4'b0, ~nor_hit};
        nand_mask_d = nand_mask_q | (8'(nand_hit) << vec_q);
        nor_mask_d  = nor_mask_q | (8'(nor_hit) << vec_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= 3'd0;
            cnt_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            nand_mask_q <= 8'h00;
            nor_mask_q  <= 8'h00;
            err_q       <= 5'd0;
`ifdef FIRST_FAIL_CAPTURE_EN
            ff_q        <= 4'd0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    // DONE restarts exactly like IDLE
                    if (start) begin
                        state_q     <= S_SETTLE;
                        vec_q       <= 3'd0;
                        cnt_q       <= SETTLE_LD;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        nand_mask_q <= 8'h00;
                        nor_mask_q  <= 8'h00;
                        err_q       <= 5'd0;
`ifdef FIRST_FAIL_CAPTURE_EN
                        ff_q        <= 4'd0;
`endif
                    end
                end
                S_SETTLE: begin
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_SAMPLE: begin
                    nand_mask_q <= nand_mask_d;
                    nor_mask_q  <= nor_mask_d;
                    err_q       <= err_d;
`ifdef FIRST_FAIL_CAPTURE_EN
                    if (!ff_q[3] && !(nand_hit && nor_hit)) begin
                        ff_q <= {1'b1, vec_q};
                    end
`endif
                    if (vec_q == 3'd7) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 5'd0);
                    end else begin
                        state_q <= S_SETTLE;
                        vec_q   <= vec_q + 3'd1;
                        cnt_q   <= SETTLE_LD;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign {A, B, C}    = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign nand_ok_mask = nand_mask_q;
    assign nor_ok_mask  = nor_mask_q;
    assign err_count    = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
    assign first_fail = ff_q;
`else
    assign first_fail = 4'b0000;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: directed bench for truth_table_sequencer.
// Gate-level NAND/NOR models with fault modes; checks run results.
module tb_truth_table_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start2 = 1'b0;
    logic [1:0] mode = 2'd0;

    logic       A, B, C, busy, done, pass;
    logic [7:0] nand_ok_mask, nor_ok_mask;
    logic [4:0] err_count;
    logic [3:0] first_fail;
    logic       y_nand, y_nor;

    logic       A2, B2, C2, busy2, done2, pass2;
    logic [7:0] nand_ok_mask2, nor_ok_mask2;
    logic [4:0] err_count2;
    logic [3:0] first_fail2;
    logic       y_nand2, y_nor2;

    int n_chk = 0;
    int n_fail = 0;

`ifdef FIRST_FAIL_CAPTURE_EN
    localparam logic [3:0] FF_V0 = 4'b1000;
`else
    localparam logic [3:0] FF_V0 = 4'b0000;
`endif

    always #5 clk = ~clk;

    // NAND-only: F = NAND(A, NAND(B,C))
    function automatic logic f_nand(input logic a, b, c);
        logic n1;
        n1 = ~(b & c);
        return ~(a & n1);
    endfunction

    // NOR-only: F = NOR(NOR(A', BC), same)
    function automatic logic f_nor(input logic a, b, c);
        logic na, nb, nc, bc, t;
        na = ~(a | a);
        nb = ~(b | b);
        nc = ~(c | c);
        bc = ~(nb | nc);
        t  = ~(na | bc);
        return ~(t | t);
    endfunction

    // mode 0: correct, 1: y_nor stuck 0,
    // 2: y_nand stuck 1 and y_nor inverted
    always_comb begin
        y_nand = f_nand(A, B, C);
        y_nor  = f_nor(A, B, C);
        if (mode == 2'd1) y_nor = 1'b0;
        if (mode == 2'd2) begin
            y_nand = 1'b1;
            y_nor  = ~f_nor(A, B, C);
        end
        y_nand2 = f_nand(A2, B2, C2);
        y_nor2  = f_nor(A2, B2, C2);
    end

    truth_table_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .y_nand(y_nand), .y_nor(y_nor),
        .A(A), .B(B), .C(C),
        .busy(busy), .done(done), .pass(pass),
        .nand_ok_mask(nand_ok_mask), .nor_ok_mask(nor_ok_mask),
        .err_count(err_count), .first_fail(first_fail)
    );

    truth_table_sequencer #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2),
        .y_nand(y_nand2), .y_nor(y_nor2),
        .A(A2), .B(B2), .C(C2),
        .busy(busy2), .done(done2), .pass(pass2),
        .nand_ok_mask(nand_ok_mask2), .nor_ok_mask(nor_ok_mask2),
        .err_count(err_count2), .first_fail(first_fail2)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "/abc"}, 32'({A, B, C}), 32'd0);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/done"}, 32'(done), 32'd0);
        check({tag, "/pass"}, 32'(pass), 32'd0);
        check({tag, "/nandm"}, 32'(nand_ok_mask), 32'd0);
        check({tag, "/norm"}, 32'(nor_ok_mask), 32'd0);
        check({tag, "/err"}, 32'(err_count), 32'd0);
        check({tag, "/ff"}, 32'(first_fail), 32'd0);
    endtask

    task automatic check_res(input string tag,
                             input logic e_pass,
                             input logic [7:0] e_nm,
                             input logic [7:0] e_rm,
                             input logic [4:0] e_err,
                             input logic [3:0] e_ff);
        check({tag, "/done"}, 32'(done), 32'd1);
        check({tag, "/busy"}, 32'(busy), 32'd0);
        check({tag, "/pass"}, 32'(pass), 32'(e_pass));
        check({tag, "/nandm"}, 32'(nand_ok_mask), 32'(e_nm));
        check({tag, "/norm"}, 32'(nor_ok_mask), 32'(e_rm));
        check({tag, "/err"}, 32'(err_count), 32'(e_err));
        check({tag, "/ff"}, 32'(first_fail), 32'(e_ff));
        check({tag, "/abc"}, 32'({A, B, C}), 32'd7);
    endtask

    // Called at a negedge with start already set up by caller
    task automatic walk(input string tag);
        for (int j = 0; j < 24; j++) begin
            check({tag, "/vec"}, 32'({A, B, C}), 32'(j / 3));
            check({tag, "/busy_run"}, 32'(busy), 32'd1);
            check({tag, "/done_run"}, 32'(done), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;

        // reset state
        #2;
        check_zero("reset");
        repeat (2) @(negedge clk);
        check_zero("reset2");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");

        // 1: correct implementations
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        walk("ok");
        check_res("ok", 1'b1, 8'hFF, 8'hFF, 5'd0, 4'd0);
        repeat (3) @(negedge clk);
        check_res("ok_hold", 1'b1, 8'hFF, 8'hFF, 5'd0, 4'd0);

        // 2: y_nor stuck at 0, restart from DONE
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("nor0/clr_nandm", 32'(nand_ok_mask), 32'd0);
        check("nor0/clr_pass", 32'(pass), 32'd0);
        walk("nor0");
        check_res("nor0", 1'b0, 8'hFF, 8'h70, 5'd5, FF_V0);

        // 3: y_nand stuck at 1, y_nor = ~F
        mode  = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        walk("nand1");
        check_res("nand1", 1'b0, 8'h8F, 8'h00, 5'd11, FF_V0);

        // 4: start held high for the whole run
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'd0;
        start = 1'b1;
        @(negedge clk);
        walk("hold");
        check_res("hold", 1'b1, 8'hFF, 8'hFF, 5'd0, 4'd0);
        @(negedge clk);
        check("hold/re_done", 32'(done), 32'd0);
        check("hold/re_busy", 32'(busy), 32'd1);
        check("hold/re_nandm", 32'(nand_ok_mask), 32'd0);
        check("hold/re_norm", 32'(nor_ok_mask), 32'd0);
        check("hold/re_abc", 32'({A, B, C}), 32'd0);
        start = 1'b0;
        repeat (23) @(negedge clk);
        check("hold/re_early", 32'(done), 32'd0);
        @(negedge clk);
        check_res("hold2", 1'b1, 8'hFF, 8'hFF, 5'd0, 4'd0);

        // 5: async reset during vector 5
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (16) @(negedge clk);
        check("arst/pre_abc", 32'({A, B, C}), 32'd5);
        check("arst/pre_nandm", 32'(nand_ok_mask), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_zero("arst_idle");

        // 6: SETTLE_CYCLES=1 instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("s1/busy", 32'(busy2), 32'd1);
        cyc = 0;
        while (!done2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("s1/latency", 32'(cyc), 32'd16);
        check("s1/pass", 32'(pass2), 32'd1);
        check("s1/nandm", 32'(nand_ok_mask2), 32'hFF);
        check("s1/norm", 32'(nor_ok_mask2), 32'hFF);
        check("s1/err", 32'(err_count2), 32'd0);
        check("s1/ff", 32'(first_fail2), 32'd0);
        check("s1/busy_end", 32'(busy2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Self-checking stimulus/response stage wrapped around the 3-input gate-level implementations of F = A' + BC.
- Upstream: drives A, B, C through all 8 input combinations.
- Downstream: samples y from the NAND-only and NOR-only implementations and compares each against the expected F.
- Reports per-vector pass masks, an error count, and a pass flag through a start/busy/done handshake.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level-sampled run request
- y_nand  input  1  output of the NAND implementation
- y_nor  input  1  output of the NOR implementation
- A  output  1  stimulus MSB (vector bit 2)
- B  output  1  stimulus (vector bit 1)
- C  output  1  stimulus LSB (vector bit 0)
- busy  output  1  run in progress
- done  output  1  run complete, results valid
- pass  output  1  all 16 comparisons matched (valid only while done=1)
- nand_ok_mask  output  8  bit i set if y_nand matched at vector i
- nor_ok_mask  output  8  bit i set if y_nor matched at vector i
- err_count  output  5  total mismatches, 0..16
- first_fail  output  4  see Optional Feature

Behaviour:
- One clock, asynchronous active-low reset.
- While rst_n=0, all outputs are 0: A=B=C=0, busy=0, done=0, pass=0, masks=0x00, err_count=0, first_fail=0. State is IDLE.
- Vector index v[2:0] maps to {A,B,C} = v. A, B and C are registered.
- Expected F = ~A | (B & C), giving EXP mask 8'h8F (vectors 0,1,2,3,7 → 1; vectors 4,5,6 → 0).
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: v=0, masks and err_count cleared, settle counter loaded with SETTLE_CYCLES, go to SETTLE, busy=1.
- SETTLE:
  - Counter decrements each cycle.
  - When it reaches 1, go to SAMPLE.
  - The vector is therefore held SETTLE_CYCLES cycles before the SAMPLE cycle.
- SAMPLE (one cycle):
  - Compare y_nand and y_nor with EXP[v].
  - Set mask bit v for each match.
  - Add 0, 1 or 2 to err_count.
  - If v==7, go to DONE. Otherwise increment v, reload the counter, go to SETTLE.
- DONE:
  - busy=0, done=1.
  - pass = (err_count==0), registered on entry.
  - Masks and err_count hold.
  - A, B, C hold at 3'b111.
  - start=1 restarts exactly as from IDLE: done drops, results clear, in the same edge.
- Latency: start accepted at edge k → done=1 after edge k + 8*(SETTLE_CYCLES+1). For SETTLE_CYCLES=2 that is 24 cycles.
- start while busy=1 is ignored. No queueing; it has no effect on the run.
- Reset mid-run aborts immediately: all outputs return to reset values, no partial results are retained, and the next run needs a fresh start.
- err_count cannot overflow: at most 16 increments per run, held in 5 bits.
- y_nand and y_nor are sampled only in SAMPLE; glitches during SETTLE are ignored.

Optional Feature:
- Macro FIRST_FAIL_CAPTURE_EN.
- Defined:
  - first_fail[3] = valid; first_fail[2:0] = index of the first vector where either implementation mismatched.
  - Captured once per run and cleared on start.
  - Held through DONE.
- Undefined: first_fail is tied to 4'b0000 and the capture logic is absent.

Test Plan:
- Correct NAND and NOR implementations connected, SETTLE_CYCLES=2, one-cycle start pulse → busy for 24 cycles; then done=1, pass=1, nand_ok_mask=0xFF, nor_ok_mask=0xFF, err_count=0. A,B,C step 000→111 with each vector held 3 cycles.
- y_nor stuck at 0, y_nand correct → nor_ok_mask=0x70, nand_ok_mask=0xFF, err_count=5, pass=0.
- y_nand stuck at 1, y_nor driven as ~F → nand_ok_mask=0x8F, nor_ok_mask=0x00, err_count=11, pass=0. With FIRST_FAIL_CAPTURE_EN, first_fail=4'b1000 (vector 0, from y_nor).
- start held high for the entire run → exactly one run, done after 24 cycles. Because start is still high in DONE, a second run begins on the next edge with done=0 and masks cleared.
- rst_n asserted asynchronously mid-cycle during vector 5 → busy, done, A/B/C, masks and err_count go to 0 immediately, without waiting for a clock edge. After release, the state stays IDLE until start.
- SETTLE_CYCLES=1 with correct implementations → done 16 cycles after start, pass=1. With the macro undefined, first_fail=0 in every scenario.
